// File: rtl/snow64_instr_cache.sv
// Direct-mapped read-only instruction cache for the snow64 fetch stage.
// Hits return one cycle after the request; misses fill the whole line via mem_req/mem_ack.
module snow64_instr_cache #(
    parameter int unsigned NUM_LINES = 32,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned ADDR_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_req,
    input  logic [ADDR_BITS-1:0] in_addr,
    input  logic                 in_flush,
    output logic                 out_valid,
    output logic [31:0]          out_instr,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [LINE_BITS-1:0] mem_data
);

    localparam int unsigned IdxBits = $clog2(NUM_LINES);
    localparam int unsigned OffBits = $clog2(LINE_BITS / 8);
    localparam int unsigned Words   = LINE_BITS / 32;
    localparam int unsigned SelBits = $clog2(Words);
    localparam int unsigned TagBits = ADDR_BITS - OffBits - IdxBits;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TagBits-1:0]     tag_q  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES][Words];

    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_instr_q, out_instr_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [IdxBits-1:0]     fill_idx_q, fill_idx_d;
    logic [TagBits-1:0]     fill_tag_q, fill_tag_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   fill_we;

    logic [IdxBits-1:0]     lk_idx;
    logic [TagBits-1:0]     lk_tag;
    logic [SelBits-1:0]     lk_sel;
    logic                   lk_hit;
    logic [31:0]            lk_word;

    always_comb begin
        lk_idx  = in_addr[OffBits +: IdxBits];
        lk_tag  = in_addr[ADDR_BITS-1 -: TagBits];
        lk_sel  = in_addr[2 +: SelBits];
        // A flush on the lookup edge forces a miss even if the line was valid.
        lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !in_flush;
        lk_word = data_q[lk_idx][lk_sel];
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        out_valid_d  = 1'b0;
        out_instr_d  = out_instr_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        fill_idx_d   = fill_idx_q;
        fill_tag_d   = fill_tag_q;
        flush_pend_d = flush_pend_q;
        fill_we      = 1'b0;

        if (in_flush) begin
            valid_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (in_req) begin
                    if (lk_hit) begin
                        out_valid_d = 1'b1;
                        out_instr_d = lk_word;
                    end else begin
                        fill_idx_d = lk_idx;
                        fill_tag_d = lk_tag;
                        mem_addr_d = {in_addr[ADDR_BITS-1:OffBits], {OffBits{1'b0}}};
                        mem_req_d  = 1'b1;
                        state_d    = StFill;
                    end
                end
            end
            StFill: begin
                if (in_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    fill_we = 1'b1;
                    // A flush seen at any point during the fill leaves the new line invalid.
                    if (!flush_pend_q && !in_flush) begin
                        valid_d[fill_idx_q] = 1'b1;
                    end
                    mem_req_d    = 1'b0;
                    flush_pend_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            fill_idx_q   <= '0;
            fill_tag_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            fill_idx_q   <= fill_idx_d;
            fill_tag_q   <= fill_tag_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Tag and data arrays are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx_q] <= fill_tag_q;
            for (int w = 0; w < int'(Words); w++) begin
                data_q[fill_idx_q][w] <= mem_data[32*w +: 32];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_snow64_instr_cache.sv
// Directed self-checking bench for snow64_instr_cache: fills, hits, conflicts,
// flush during a fill, reset during a fill and request toggling.
module tb_snow64_instr_cache;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_req = 1'b0;
    logic [63:0]  in_addr = '0;
    logic         in_flush = 1'b0;
    logic         out_valid;
    logic [31:0]  out_instr;
    logic         mem_req;
    logic [63:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [255:0] mem_data = '0;

    int checks = 0;
    int errors = 0;

    snow64_instr_cache dut (
        .clk       (clk),
        .rst       (rst),
        .in_req    (in_req),
        .in_addr   (in_addr),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    // Memory contents: word 0 of line 0x1000 is 0xDEADBEEF; other words/lines differ.
    function automatic logic [31:0] wexp(input logic [63:0] a);
        logic [31:0] base;
        int          i;
        base = {a[31:5], 5'b0};
        i    = int'(a[4:2]);
        return 32'hDEADBEEF ^ (base - 32'h1000) ^ (i * 32'h01110000);
    endfunction

    function automatic logic [255:0] mkline(input logic [63:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = wexp({base[63:5], 5'b0} + 64'(4 * i));
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Miss on a, ack after dly fill cycles, then the repeated lookup must hit.
    task automatic do_miss(input string tag, input logic [63:0] a, input int dly);
        in_req  = 1'b1;
        in_addr = a;
        tick();
        chk({tag, "_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_addr"}, mem_addr, {a[63:5], 5'b0});
        chk({tag, "_nv"}, 64'(out_valid), 64'd0);
        for (int k = 1; k < dly; k++) begin
            tick();
            chk({tag, "_hold"}, 64'(mem_req), 64'd1);
            chk({tag, "_holdnv"}, 64'(out_valid), 64'd0);
        end
        mem_ack  = 1'b1;
        mem_data = mkline(a);
        tick();
        mem_ack  = 1'b0;
        chk({tag, "_ackreq"}, 64'(mem_req), 64'd0);
        chk({tag, "_acknv"}, 64'(out_valid), 64'd0);
        tick();
        chk({tag, "_v"}, 64'(out_valid), 64'd1);
        chk({tag, "_instr"}, 64'(out_instr), 64'(wexp(a)));
    endtask

    task automatic do_hit(input string tag, input logic [63:0] a);
        in_req  = 1'b1;
        in_addr = a;
        tick();
        chk({tag, "_v"}, 64'(out_valid), 64'd1);
        chk({tag, "_instr"}, 64'(out_instr), 64'(wexp(a)));
        chk({tag, "_noreq"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_memreq", 64'(mem_req), 64'd0);
        chk("rst_memaddr", mem_addr, 64'd0);
        tick();
        tick();
        rst = 1'b0;

        do_miss("fill1000", 64'h1000, 2);
        chk("word0_const", 64'(out_instr), 64'hDEADBEEF);

        for (int i = 1; i < 8; i++) begin
            do_hit("seq", 64'h1000 + 64'(4 * i));
        end
        do_hit("stall0", 64'h101C);
        do_hit("stall1", 64'h101C);

        do_hit("tog1", 64'h1008);
        in_req = 1'b0;
        tick();
        chk("tog0_v", 64'(out_valid), 64'd0);
        chk("tog0_hold", 64'(out_instr), 64'(wexp(64'h1008)));
        do_hit("tog2", 64'h1008);

        in_req   = 1'b0;
        mem_ack  = 1'b1;
        mem_data = '1;
        tick();
        mem_ack  = 1'b0;
        chk("idleack_req", 64'(mem_req), 64'd0);
        chk("idleack_v", 64'(out_valid), 64'd0);
        do_hit("idleack_hit", 64'h1000);

        do_miss("conf1400", 64'h1400, 1);
        do_miss("conf1000", 64'h1000, 1);
        do_hit("conf1000hit", 64'h1004);

        in_req  = 1'b1;
        in_addr = 64'h2000;
        tick();
        chk("fl_req", 64'(mem_req), 64'd1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        chk("fl_hold", 64'(mem_req), 64'd1);
        chk("fl_nv", 64'(out_valid), 64'd0);
        tick();
        chk("fl_hold2", 64'(mem_req), 64'd1);
        mem_ack  = 1'b1;
        mem_data = mkline(64'h2000);
        tick();
        mem_ack = 1'b0;
        chk("fl_ackreq", 64'(mem_req), 64'd0);
        tick();
        chk("fl_remiss_req", 64'(mem_req), 64'd1);
        chk("fl_remiss_nv", 64'(out_valid), 64'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("fl_refill_v", 64'(out_valid), 64'd1);
        chk("fl_refill_instr", 64'(out_instr), 64'(wexp(64'h2000)));

        do_miss("pre_rst", 64'h1000, 1);
        in_addr = 64'h1400;
        tick();
        chk("rstfill_req", 64'(mem_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstasync_req", 64'(mem_req), 64'd0);
        chk("rstasync_v", 64'(out_valid), 64'd0);
        tick();
        rst     = 1'b0;
        in_addr = 64'h1000;
        tick();
        chk("postrst_miss", 64'(mem_req), 64'd1);
        chk("postrst_nv", 64'(out_valid), 64'd0);
        chk("postrst_addr", mem_addr, 64'h1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
